// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared state encoding and sizing helper for the UART TX feeder
package uart_tx_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_t;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// rtl/uart_tx_feeder_sync_fifo.sv - circular synchronous FIFO with occupancy count and reject flag
module sync_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    wr_reject
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_rd;
    logic                  do_wr;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign rd_data   = mem[rd_ptr];
    assign do_rd     = rd_en && !empty;
    // A same-cycle pop frees a slot, so a write into a full FIFO still lands.
    assign do_wr     = wr_en && (!full || do_rd);
    assign wr_reject = wr_en && !do_wr;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered byte feeder issuing one valid pulse per transmitter frame
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_en,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         hs_error,
    input  logic                         err_clr,
    output logic [DATA_WIDTH-1:0]        tx_p_data,
    output logic                         tx_data_valid,
    input  logic                         tx_busy
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(BUSY_TIMEOUT);

    feeder_state_t         state;
    feeder_state_t         state_next;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_next;
    logic                  pop;
    logic                  timeout;
    logic                  wr_reject;
    logic [DATA_WIDTH-1:0] head;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (pop),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .wr_reject (wr_reject)
    );

    always_comb begin
        state_next = state;
        timer_next = timer;
        pop        = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                timer_next = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else begin
                    // Abandon the byte rather than retry; a re-send could duplicate a frame.
                    timer_next = timer + 1'b1;
                    if (timer_next == TIMEOUT_VAL) begin
                        timeout    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            overflow      <= 1'b0;
            hs_error      <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            tx_data_valid <= pop;
            if (pop) begin
                tx_p_data <= head;
            end
            if (wr_reject) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (timeout) begin
                hs_error <= 1'b1;
            end else if (err_clr) begin
                hs_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench with a transmitter busy model for uart_tx_feeder
module tb_uart_tx_feeder;

    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       hs_error;
    logic       err_clr;
    logic [7:0] tx_p_data;
    logic       tx_data_valid;
    logic       tx_busy;
    logic       hold_busy = 1'b0;
    logic       model_busy = 1'b0;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_pulses = 0;
    int         last_pulse_cyc = 0;
    int         busy_cnt = 0;
    bit         rise_pending = 1'b0;
    bit         skip_busy = 1'b0;
    bit         prev_had_busy = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] exp_q [$];

    assign tx_busy = hold_busy | model_busy;

    uart_tx_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .hs_error      (hs_error),
        .err_clr       (err_clr),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy rises one cycle after each pulse and holds for BUSY_LEN cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) model_busy = 1'b0;
            end
            if (rise_pending) begin
                rise_pending = 1'b0;
                model_busy   = 1'b1;
                busy_cnt     = BUSY_LEN;
            end
            if (tx_data_valid) begin
                check("single_cycle_valid", {31'd0, prev_valid}, 32'd0);
                if (prev_had_busy)
                    check("pulse_gap", {31'd0, (cyc - last_pulse_cyc) >= BUSY_LEN + 2}, 32'd1);
                check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("tx_byte", {24'd0, tx_p_data}, {24'd0, exp_q.pop_front()});
                n_pulses++;
                last_pulse_cyc = cyc;
                if (skip_busy) begin
                    skip_busy     = 1'b0;
                    prev_had_busy = 1'b0;
                end else begin
                    rise_pending  = 1'b1;
                    prev_had_busy = 1'b1;
                end
            end
            prev_valid = tx_data_valid;
        end
    end

    task automatic write_byte(input logic [7:0] b, input bit accept);
        wr_data = b;
        wr_en   = 1'b1;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int n = 0;
        while (n_pulses < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, n_pulses >= target}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rel_cyc;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0;
        idle_cycles(2);
        check("rst_empty", {31'd0, fifo_empty}, 32'd1);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_valid", {31'd0, tx_data_valid}, 32'd0);
        check("rst_pdata", {24'd0, tx_p_data}, 32'd0);
        check("rst_flags", {30'd0, overflow, hs_error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte.
        write_byte(8'hA5, 1'b1);
        wait_pulses(1, 30, "t1_pulse");
        idle_cycles(20);
        check("t1_pulse_count", n_pulses, 32'd1);
        check("t1_empty", {31'd0, fifo_empty}, 32'd1);

        // Busy held high while filling: fill to full, overflow, then drain in order.
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) write_byte(8'(i), 1'b1);
        check("t2_full", {31'd0, fifo_full}, 32'd1);
        check("t2_count", {28'd0, fifo_count}, 32'd8);
        write_byte(8'hFF, 1'b0);
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        check("t3_count", {28'd0, fifo_count}, 32'd8);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3_overflow_clr", {31'd0, overflow}, 32'd0);
        idle_cycles(4);
        check("t6_no_pulse_while_busy", n_pulses, 32'd1);
        hold_busy = 1'b0;
        rel_cyc = cyc;
        wait_pulses(2, 5, "t6_first_pulse");
        check("t6_latency", {31'd0, (last_pulse_cyc - rel_cyc) >= 1 && (last_pulse_cyc - rel_cyc) <= 2}, 32'd1);
        wait_pulses(9, 400, "t2_drain");
        idle_cycles(20);
        check("t2_empty", {31'd0, fifo_empty}, 32'd1);
        check("t2_sb_drained", exp_q.size(), 32'd0);
        check("t3_no_hs_error", {31'd0, hs_error}, 32'd0);

        // Transmitter ignores the pulse for 0x3C.
        base = n_pulses;
        skip_busy = 1'b1;
        write_byte(8'h3C, 1'b1);
        write_byte(8'h3D, 1'b1);
        wait_pulses(base + 1, 10, "t4_3c_pulse");
        idle_cycles(4);
        check("t4_hs_error_pre", {31'd0, hs_error}, 32'd0);
        @(negedge clk);
        check("t4_hs_error", {31'd0, hs_error}, 32'd1);
        wait_pulses(base + 2, 10, "t4_3d_pulse");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_hs_error_clr", {31'd0, hs_error}, 32'd0);
        idle_cycles(20);

        // Reset in WAIT_DONE with three bytes queued.
        base = n_pulses;
        for (int i = 0; i < 4; i++) write_byte(8'h50 + 8'(i), 1'b1);
        check("t5_pulse_before_rst", n_pulses, base + 1);
        check("t5_count_before_rst", {28'd0, fifo_count}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("t5_count", {28'd0, fifo_count}, 32'd0);
        check("t5_valid", {31'd0, tx_data_valid}, 32'd0);
        check("t5_pdata", {24'd0, tx_p_data}, 32'd0);
        idle_cycles(30);
        check("t5_no_more_pulses", n_pulses, base + 1);
        check("t5_empty", {31'd0, fifo_empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
